// File: rtl/lcd_writer.sv
// Byte sequencer for an HD44780-style LCD: sends 1..4 bytes per job with
// SETUP/PULSE/HOLD(/WAIT) timing, started by a falling edge on lcd_enable.
module lcd_writer (
  input  logic        clk_1ms,
  input  logic        reset,
  input  logic        lcd_enable,
  input  logic [1:0]  lcd_cnt,
  input  logic        mode,
  input  logic        DB_sel,
  input  logic        data_sel,
  input  logic        reg_sel,
  input  logic [31:0] disp_data,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_db,
  output logic        lcd_finish,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic        en_q;
  logic [1:0]  idx, idx_n;
  logic        wcnt, wcnt_n;
  logic [1:0]  cnt_q;
  logic        mode_q, db_sel_q, data_sel_q, rs_q;
  logic [31:0] data_q;
  logic        start, abort, byte_end;

  // On the start edge the job fields are not latched yet, so read the inputs.
  logic        s_db_sel, s_data_sel, s_rs;
  logic [31:0] s_data;

  function automatic logic [7:0] sel_byte(input logic db, input logic ds,
                                          input logic [31:0] d, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h80;
    if (db) begin
      if (ds) begin
        case (i)
          2'd0:    b = d[31:24];
          2'd1:    b = d[23:16];
          2'd2:    b = d[15:8];
          default: b = d[7:0];
        endcase
      end else begin
        case (i)
          2'd0:    b = 8'h38;
          2'd1:    b = 8'h0C;
          2'd2:    b = 8'h06;
          default: b = 8'h01;
        endcase
      end
    end
    return b;
  endfunction

  assign start      = (state == IDLE) && en_q && !lcd_enable;
  assign abort      = lcd_enable && (state != IDLE) && (state != DONE);
  assign s_db_sel   = start ? DB_sel    : db_sel_q;
  assign s_data_sel = start ? data_sel  : data_sel_q;
  assign s_rs       = start ? reg_sel   : rs_q;
  assign s_data     = start ? disp_data : data_q;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    wcnt_n   = wcnt;
    byte_end = 1'b0;
    case (state)
      IDLE:  if (start) begin state_n = SETUP; idx_n = 2'd0; end
      SETUP: state_n = PULSE;
      PULSE: state_n = HOLD;
      HOLD:  if (mode_q) begin state_n = WAIT; wcnt_n = 1'b0; end
             else byte_end = 1'b1;
      WAIT:  if (wcnt) byte_end = 1'b1;
             else wcnt_n = 1'b1;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (byte_end) begin
      if (idx == cnt_q) state_n = DONE;
      else begin
        state_n = SETUP;
        idx_n   = idx + 2'd1;
      end
    end
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      wcnt       <= 1'b0;
      en_q       <= 1'b1;
      cnt_q      <= 2'd0;
      mode_q     <= 1'b0;
      db_sel_q   <= 1'b0;
      data_sel_q <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 32'h0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_db     <= 8'h00;
      lcd_finish <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wcnt       <= wcnt_n;
      en_q       <= lcd_enable;
      if (start) begin
        cnt_q      <= lcd_cnt;
        mode_q     <= mode;
        db_sel_q   <= DB_sel;
        data_sel_q <= data_sel;
        rs_q       <= reg_sel;
        data_q     <= disp_data;
      end
      // Outputs registered against the next state so they line up with it.
      lcd_e      <= (state_n == PULSE);
      lcd_finish <= (state_n == DONE);
      if (state_n == SETUP) begin
        lcd_db <= sel_byte(s_db_sel, s_data_sel, s_data, idx_n);
        lcd_rs <= s_rs;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer: stimulus pushes expected strobes/finishes
// with their cycle stamps; a monitor pops and compares as the DUT emits them.
module tb_lcd_writer;

  logic        clk_1ms = 1'b0;
  logic        reset;
  logic        lcd_enable;
  logic [1:0]  lcd_cnt;
  logic        mode, DB_sel, data_sel, reg_sel;
  logic [31:0] disp_data;
  logic        lcd_e, lcd_rs, lcd_rw, lcd_finish, busy;
  logic [7:0]  lcd_db;

  lcd_writer dut (
    .clk_1ms(clk_1ms), .reset(reset), .lcd_enable(lcd_enable), .lcd_cnt(lcd_cnt),
    .mode(mode), .DB_sel(DB_sel), .data_sel(data_sel), .reg_sel(reg_sel),
    .disp_data(disp_data), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .lcd_finish(lcd_finish), .busy(busy)
  );

  always #5 clk_1ms = ~clk_1ms;

  typedef struct {
    logic       fin;
    logic       rs;
    logic [7:0] db;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_1ms) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one comparison per lcd_e rising edge and per lcd_finish cycle.
  initial begin
    logic prev_e;
    exp_t e;
    prev_e = 1'b0;
    forever begin
      @(negedge clk_1ms);
      if (!reset) begin
        if (lcd_e && !prev_e) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].fin) begin
            failures++;
            $display("FAIL strobe: unexpected lcd_e db=%h rs=%b at cycle %0d", lcd_db, lcd_rs, cyc);
          end else begin
            e = exp_q.pop_front();
            if (lcd_db !== e.db || lcd_rs !== e.rs || cyc != e.cyc) begin
              failures++;
              $display("FAIL strobe: got db=%h rs=%b cyc=%0d expected db=%h rs=%b cyc=%0d",
                       lcd_db, lcd_rs, cyc, e.db, e.rs, e.cyc);
            end
          end
        end
        if (lcd_finish) begin
          checks++;
          if (exp_q.size() == 0 || !exp_q[0].fin) begin
            failures++;
            $display("FAIL finish: unexpected lcd_finish at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc) begin
              failures++;
              $display("FAIL finish: got cycle %0d expected cycle %0d", cyc, e.cyc);
            end
          end
        end
      end
      prev_e = lcd_e;
    end
  end

  task automatic push_job(input int c, input logic m, input logic rs, input logic [1:0] cnt,
                          input logic [31:0] bytes, input logic with_fin, input int nbytes);
    int per;
    exp_t e;
    per = m ? 5 : 3;
    for (int k = 0; k < nbytes; k++) begin
      e.fin = 1'b0; e.rs = rs; e.db = bytes[31-8*k -: 8]; e.cyc = c + 2 + k*per;
      exp_q.push_back(e);
    end
    if (with_fin) begin
      e.fin = 1'b1; e.rs = 1'b0; e.db = 8'h00; e.cyc = c + 1 + (int'(cnt) + 1)*per;
      exp_q.push_back(e);
    end
  endtask

  // Full job: bytes are hand-computed expectations; scramble perturbs inputs mid-job.
  task automatic job(input logic m, input logic dbs, input logic ds, input logic rs,
                     input logic [1:0] cnt, input logic [31:0] data, input logic [31:0] bytes,
                     input logic scramble, input int extra_low);
    int c, len;
    @(negedge clk_1ms);
    mode = m; DB_sel = dbs; data_sel = ds; reg_sel = rs; lcd_cnt = cnt; disp_data = data;
    lcd_enable = 1'b0;
    c = cyc;
    len = (int'(cnt) + 1) * (m ? 5 : 3);
    push_job(c, m, rs, cnt, bytes, 1'b1, int'(cnt) + 1);
    for (int i = 0; i < len + 2 + extra_low; i++) begin
      @(negedge clk_1ms);
      if (i == 1 && scramble) begin
        disp_data = ~disp_data; DB_sel = ~DB_sel; data_sel = ~data_sel;
        reg_sel = ~reg_sel; mode = ~mode; lcd_cnt = 2'd0;
      end
      if (i == 0) chk("busy_in_job", busy, 1);
    end
    chk("busy_after_job", busy, 0);
    lcd_enable = 1'b1;
    @(negedge clk_1ms);
  endtask

  initial begin
    int c;
    reset = 1'b1; lcd_enable = 1'b1; lcd_cnt = 0; mode = 0; DB_sel = 0;
    data_sel = 0; reg_sel = 0; disp_data = 0;
    repeat (2) @(negedge clk_1ms);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_db", lcd_db, 8'h00);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_finish", lcd_finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rw", lcd_rw, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_1ms);

    // Init job, address job, refresh job (with mid-job input changes)
    job(1, 1, 0, 0, 2'd3, 32'h0, 32'h380C0601, 0, 0);
    job(0, 0, 0, 0, 2'd0, 32'h0, 32'h80000000, 0, 0);
    job(0, 1, 1, 1, 2'd3, 32'h31323334, 32'h31323334, 1, 0);
    chk("db_holds_idle", lcd_db, 8'h34);
    chk("rs_holds_idle", lcd_rs, 1);
    // Enable held low well past DONE: no retrigger
    job(0, 0, 0, 0, 2'd0, 32'h0, 32'h80000000, 0, 8);

    // Abort during the second byte of a refresh job
    @(negedge clk_1ms);
    mode = 0; DB_sel = 1; data_sel = 1; reg_sel = 1; lcd_cnt = 3; disp_data = 32'h41424344;
    lcd_enable = 1'b0; c = cyc;
    push_job(c, 0, 1, 2'd3, 32'h41424344, 1'b0, 1);
    repeat (4) @(negedge clk_1ms);
    chk("abort_busy_before", busy, 1);
    lcd_enable = 1'b1;
    @(negedge clk_1ms);
    chk("abort_busy", busy, 0);
    chk("abort_lcd_e", lcd_e, 0);
    repeat (6) @(negedge clk_1ms);

    // Reset during PULSE of an init job
    @(negedge clk_1ms);
    mode = 1; DB_sel = 1; data_sel = 0; reg_sel = 0; lcd_cnt = 3;
    lcd_enable = 1'b0; c = cyc;
    push_job(c, 1, 0, 2'd3, 32'h38000000, 1'b0, 1);
    repeat (2) @(negedge clk_1ms);
    chk("pulse_before_reset", lcd_e, 1);
    #1 reset = 1'b1;
    #1;
    chk("reset_async_lcd_e", lcd_e, 0);
    chk("reset_async_finish", lcd_finish, 0);
    chk("reset_async_db", lcd_db, 8'h00);
    chk("reset_async_busy", busy, 0);
    lcd_enable = 1'b1;
    repeat (2) @(negedge clk_1ms);
    reset = 1'b0;
    @(negedge clk_1ms);

    // Main-controller sequence after reset: init, then alternating address/refresh
    job(1, 1, 0, 0, 2'd3, 32'h0, 32'h380C0601, 0, 0);
    job(0, 0, 0, 0, 2'd1, 32'h0, 32'h80800000, 0, 0);
    job(0, 1, 1, 1, 2'd1, 32'h48490000, 32'h48490000, 0, 0);
    job(0, 0, 0, 0, 2'd0, 32'h0, 32'h80000000, 0, 3);
    job(0, 1, 1, 1, 2'd2, 32'h7A61625F, 32'h7A616200, 0, 0);
    repeat (4) @(negedge clk_1ms);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
